sdram_responder: RTL and testbench



---
 rtl/sdram_pkg.sv | 58 +++++
 rtl/sdram_mem.sv | 37 +++
 rtl/sdram_responder.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM device-side responder.
//   - command encodings {ras_n, cas_n, we_n} (also used by sdram_ctl)
//   - sticky error codes
//   - init-sequence FSM states
//   - mode-register field positions and a legality helper
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_NOP   = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_INIT_SEQ      = 3'd1,
        ERR_ACT_OPEN      = 3'd2,
        ERR_ACCESS_CLOSED = 3'd3,
        ERR_REF_OPEN      = 3'd4,
        ERR_MODE_UNSUP    = 3'd5,
        ERR_BUS_CONFLICT  = 3'd6
    } err_code_e;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_WAIT_PRE,
        ST_WAIT_REF,
        ST_WAIT_MRS,
        ST_READY
    } init_state_e;

    localparam int unsigned MODE_CL_LSB = 4;
    localparam int unsigned MODE_CL_MSB = 6;
    localparam int unsigned MODE_BL_LSB = 0;
    localparam int unsigned MODE_BL_MSB = 2;
    localparam int unsigned ADDR_A10    = 10;

    // Deselected, clock-disabled and the unused 110 encoding all act as NOP.
    function automatic cmd_e decode_cmd(input logic cs_n, input logic cke,
                                        input logic [2:0] raw);
        cmd_e c;
        c = CMD_NOP;
        if (!cs_n && cke && raw != 3'b110) begin
            c = cmd_e'(raw);
        end
        return c;
    endfunction

    // Only CL2/CL3 with burst length 1 are supported.
    function automatic logic mode_legal(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'b000);
    endfunction

endpackage

// File: rtl/sdram_mem.sv
// sdram_mem: single-port synchronous backing RAM, 2**MEM_AW x 16.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write, 0 = read
//   be    : byte write enables {high, low}
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (one-cycle latency, holds between reads)
// Contents are not reset.
module sdram_mem
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [MEM_AW-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] ram [0:(1 << MEM_AW) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (be[0]) ram[addr][7:0]  <= wdata[7:0];
                if (be[1]) ram[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= ram[addr];
            end
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device emulator answering sdram_ctl on the dram_* bus.
//   clk                        : clock (same net as dram_clk), rising-edge sampling
//   rst                        : synchronous active-low reset
//   dram_cs_n/ras_n/cas_n/we_n : command pins
//   dram_cke                   : clock enable, low = cycle treated as NOP
//   dram_ba, dram_addr         : bank, row or {A10, column}
//   dram_ldqm, dram_udqm       : byte write masks
//   dram_dq                    : data bus, driven only in a read data slot
//   init_done                  : init sequence complete
//   err, err_code              : sticky first protocol violation
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned INIT_WAIT = 5000,
    parameter int unsigned MIN_REFS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dram_cke,
    input  logic        dram_cs_n,
    input  logic        dram_ras_n,
    input  logic        dram_cas_n,
    input  logic        dram_we_n,
    input  logic [1:0]  dram_ba,
    input  logic [12:0] dram_addr,
    input  logic        dram_ldqm,
    input  logic        dram_udqm,
    inout  logic [15:0] dram_dq,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code
);

    cmd_e        cmd;
    init_state_e state, state_n;
    logic [31:0] wait_cnt, wait_n;
    logic [31:0] ref_cnt, ref_n;
    logic [3:0]  bank_open, open_n;
    logic [12:0] bank_row [4];
    logic [12:0] row_n [4];
    logic        cl3, cl3_n;
    err_code_e   err_q, new_err;

    logic              mem_en, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_rdata;

    // Read pipeline: stage 1 data is the RAM's registered output.
    logic        s1_v, s1_v_n, s2_v, s3_v;
    logic [15:0] s2_d, s3_d;
    logic        drive_v, write_now, a10;
    logic [15:0] drive_d;

    assign cmd       = decode_cmd(dram_cs_n, dram_cke, {dram_ras_n, dram_cas_n, dram_we_n});
    assign a10       = dram_addr[ADDR_A10];
    assign write_now = (cmd == CMD_WRITE);
    assign mem_addr  = MEM_AW'({dram_ba, bank_row[dram_ba], dram_addr[9:0]});

    // The slot in the output register is the one the controller samples at
    // the coming edge. A WRITE presented in that same cycle releases the bus
    // combinationally so the controller's write data is not overdriven.
    assign drive_v = cl3 ? s3_v : s2_v;
    assign drive_d = cl3 ? s3_d : s2_d;
    assign dram_dq = (drive_v && !write_now) ? drive_d : 'z;

    assign init_done = (state == ST_READY);
    assign err_code  = err_q;

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        ref_n   = ref_cnt;
        open_n  = bank_open;
        row_n   = bank_row;
        cl3_n   = cl3;
        new_err = ERR_NONE;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        s1_v_n  = 1'b0;

        unique case (state)
            ST_PWR_WAIT: begin
                if (cmd != CMD_NOP) new_err = ERR_INIT_SEQ;
                // The post-reset cycle (counter 0) is the first wait cycle, so
                // the last NOP-only sample is taken at count INIT_WAIT-2.
                if (wait_cnt + 32'd2 >= 32'(INIT_WAIT)) state_n = ST_WAIT_PRE;
                else                                    wait_n  = wait_cnt + 32'd1;
            end
            ST_WAIT_PRE: begin
                if (cmd == CMD_PRE && a10) begin
                    ref_n   = '0;
                    state_n = (MIN_REFS == 0) ? ST_WAIT_MRS : ST_WAIT_REF;
                end
            end
            ST_WAIT_REF: begin
                if (cmd == CMD_REF) begin
                    ref_n = ref_cnt + 32'd1;
                    if (ref_cnt + 32'd1 >= 32'(MIN_REFS)) state_n = ST_WAIT_MRS;
                end else if (cmd == CMD_MRS) begin
                    new_err = ERR_INIT_SEQ;
                end
            end
            ST_WAIT_MRS: begin
                if (cmd == CMD_MRS) state_n = ST_READY;
            end
            ST_READY: ;
            default: state_n = ST_PWR_WAIT;
        endcase

        // Commands are ignored entirely during the power-up wait.
        if (state != ST_PWR_WAIT) begin
            case (cmd)
                CMD_ACT: begin
                    if (state != ST_READY)       new_err = ERR_INIT_SEQ;
                    else if (bank_open[dram_ba]) new_err = ERR_ACT_OPEN;
                    else begin
                        open_n[dram_ba] = 1'b1;
                        row_n[dram_ba]  = dram_addr;
                    end
                end
                CMD_READ: begin
                    if (state != ST_READY)        new_err = ERR_INIT_SEQ;
                    else if (!bank_open[dram_ba]) new_err = ERR_ACCESS_CLOSED;
                    else begin
                        mem_en = 1'b1;
                        s1_v_n = 1'b1;
                        if (a10) open_n[dram_ba] = 1'b0;
                    end
                end
                CMD_WRITE: begin
                    if (state != ST_READY)        new_err = ERR_INIT_SEQ;
                    else if (!bank_open[dram_ba]) new_err = ERR_ACCESS_CLOSED;
                    else begin
                        mem_en = 1'b1;
                        mem_we = 1'b1;
                        if (a10)     open_n[dram_ba] = 1'b0;
                        if (drive_v) new_err = ERR_BUS_CONFLICT;
                    end
                end
                CMD_PRE: begin
                    if (a10) open_n = '0;
                    else     open_n[dram_ba] = 1'b0;
                end
                CMD_REF: begin
                    if (|bank_open) new_err = ERR_REF_OPEN;
                end
                CMD_MRS: begin
                    if (state == ST_READY || state == ST_WAIT_MRS) begin
                        if (mode_legal(dram_addr[MODE_CL_MSB:MODE_CL_LSB],
                                       dram_addr[MODE_BL_MSB:MODE_BL_LSB]))
                            cl3_n = dram_addr[MODE_CL_LSB];
                        else
                            new_err = ERR_MODE_UNSUP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_PWR_WAIT;
            wait_cnt  <= '0;
            ref_cnt   <= '0;
            bank_open <= '0;
            cl3       <= 1'b0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            err       <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            ref_cnt   <= ref_n;
            bank_open <= open_n;
            bank_row  <= row_n;
            cl3       <= cl3_n;
            s1_v      <= s1_v_n;
            s2_v      <= s1_v;
            s2_d      <= mem_rdata;
            s3_v      <= s2_v;
            s3_d      <= s2_d;
            if (!err && new_err != ERR_NONE) begin
                err   <= 1'b1;
                err_q <= new_err;
            end
        end
    end

    sdram_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en && rst),
        .we    (mem_we),
        .be    ({~dram_udqm, ~dram_ldqm}),
        .addr  (mem_addr),
        .wdata (dram_dq),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed protocol sequence plus a randomized
// read/write phase checked against a word-array model of the device.
module tb_sdram_responder;
    import sdram_pkg::*;

    localparam int unsigned AW   = 12;
    localparam int unsigned IW   = 5000;
    localparam int unsigned NREF = 2;
    // The bus is pulled up, so a cycle with no driver reads as all-ones.
    localparam logic [15:0] IDLE = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        tb_oe;
    logic [15:0] tb_dq;
    wire  [15:0] dq_bus;
    logic        init_done, err;
    logic [2:0]  err_code;

    assign dq_bus = tb_oe ? tb_dq : 'z;
    pullup (dq_bus);

    sdram_responder #(
        .MEM_AW    (AW),
        .INIT_WAIT (IW),
        .MIN_REFS  (NREF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dram_cke   (cke),
        .dram_cs_n  (cs_n),
        .dram_ras_n (ras_n),
        .dram_cas_n (cas_n),
        .dram_we_n  (we_n),
        .dram_ba    (ba),
        .dram_addr  (addr),
        .dram_ldqm  (ldqm),
        .dram_udqm  (udqm),
        .dram_dq    (dq_bus),
        .init_done  (init_done),
        .err        (err),
        .err_code   (err_code)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] dq_seen;
    int unsigned edge_n = 0;

    logic [15:0]  model [int unsigned];
    logic [15:0]  due   [int unsigned];
    int unsigned  rows  [4];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input cmd_e c, input logic [1:0] b, input logic [12:0] a,
                         input logic lm = 1'b0, input logic um = 1'b0,
                         input logic oe = 1'b0, input logic [15:0] d = 16'h0);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b; addr = a; ldqm = lm; udqm = um; tb_oe = oe; tb_dq = d;
    endtask

    // dq_seen holds what the controller samples at the edge that ends the step.
    task automatic tick();
        @(negedge clk);
        dq_seen = dq_bus;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic step(input cmd_e c, input logic [1:0] b = 2'd0, input logic [12:0] a = 13'd0,
                        input logic lm = 1'b0, input logic um = 1'b0,
                        input logic oe = 1'b0, input logic [15:0] d = 16'h0);
        drive(c, b, a, lm, um, oe, d);
        tick();
    endtask

    task automatic nops(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(CMD_NOP);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(CMD_NOP);
        rst = 1'b1;
    endtask

    task automatic init_seq();
        nops(IW);
        step(CMD_PRE, 2'd0, 13'h400);
        repeat (9) step(CMD_REF);
        step(CMD_MRS, 2'd0, 13'h020);
    endtask

    function automatic int unsigned widx(input int unsigned b, input int unsigned r,
                                         input int unsigned c);
        return ((b << 23) | (r << 10) | c) % (32'd1 << AW);
    endfunction

    task automatic model_write(input int unsigned b, input int unsigned c, input logic [15:0] d,
                               input logic lm, input logic um);
        int unsigned i;
        logic [15:0] old;
        i   = widx(b, rows[b], c);
        old = model.exists(i) ? model[i] : 16'h0;
        model[i] = {um ? old[15:8] : d[15:8], lm ? old[7:0] : d[7:0]};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned cl, e, op, b, c;
        logic        slot, lm, um;
        logic [15:0] d, exp;

        rst = 1'b1; cke = 1'b1;
        drive(CMD_NOP, 2'd0, 13'd0);

        // Reset state and the last NOP-only cycle of the power-up wait.
        do_reset();
        check("rst_init_done", init_done, 16'd0);
        check("rst_err", err, 16'd0);
        check("rst_err_code", err_code, 16'd0);
        step(CMD_NOP);
        check("rst_dq_idle", dq_seen, IDLE);
        nops(IW - 3);
        step(CMD_PRE, 2'd0, 13'h400);
        check("pwr_wait_last_err_code", err_code, 16'd1);

        // 4999 NOPs then PRE-all is legal; MRS after one REF is not.
        do_reset();
        nops(IW - 1);
        step(CMD_PRE, 2'd0, 13'h400);
        check("pre_after_wait_init_done", init_done, 16'd0);
        check("pre_after_wait_err", err, 16'd0);
        step(CMD_REF);
        step(CMD_MRS, 2'd0, 13'h020);
        check("mrs_few_refs_err_code", err_code, 16'd1);
        check("mrs_few_refs_init_done", init_done, 16'd0);

        // ACT during the power-up wait.
        do_reset();
        nops(9);
        step(CMD_ACT, 2'd1, 13'h0055);
        check("act_early_err", err, 16'd1);
        check("act_early_err_code", err_code, 16'd1);

        // Full init, CL2 read-back, access to a closed bank.
        do_reset();
        init_seq();
        check("init_done", init_done, 16'd1);
        check("init_err", err, 16'd0);
        step(CMD_ACT, 2'd1, 13'h0055);
        step(CMD_WRITE, 2'd1, 13'h003, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        step(CMD_READ, 2'd1, 13'h403);
        check("cl2_dq_T", dq_seen, IDLE);
        step(CMD_NOP); check("cl2_dq_T1", dq_seen, IDLE);
        step(CMD_NOP); check("cl2_dq_T2", dq_seen, 16'hBEEF);
        step(CMD_NOP); check("cl2_dq_T3", dq_seen, IDLE);
        step(CMD_READ, 2'd1, 13'h003);
        check("read_closed_err_code", err_code, 16'd3);
        step(CMD_NOP); step(CMD_NOP);
        check("read_closed_no_drive", dq_seen, IDLE);

        // CL3 with a masked high byte.
        step(CMD_MRS, 2'd0, 13'h030);
        step(CMD_ACT, 2'd1, 13'h0055);
        step(CMD_WRITE, 2'd1, 13'h005, 1'b0, 1'b0, 1'b1, 16'h1234);
        step(CMD_WRITE, 2'd1, 13'h005, 1'b0, 1'b1, 1'b1, 16'hABCD);
        step(CMD_READ, 2'd1, 13'h005);
        step(CMD_NOP); check("cl3_dq_T1", dq_seen, IDLE);
        step(CMD_NOP); check("cl3_dq_T2", dq_seen, IDLE);
        step(CMD_NOP); check("cl3_dq_T3_mask", dq_seen, 16'h12CD);
        check("first_code_kept", err_code, 16'd3);

        // ACT to an open bank leaves the row alone.
        do_reset();
        init_seq();
        step(CMD_ACT, 2'd2, 13'h0020);
        step(CMD_ACT, 2'd2, 13'h0021);
        check("act_open_err_code", err_code, 16'd2);
        step(CMD_WRITE, 2'd2, 13'h001, 1'b0, 1'b0, 1'b1, 16'h0A0A);
        step(CMD_PRE, 2'd2, 13'h000);
        step(CMD_ACT, 2'd2, 13'h0020);
        step(CMD_READ, 2'd2, 13'h001);
        step(CMD_NOP); step(CMD_NOP);
        check("act_open_row_kept", dq_seen, 16'h0A0A);

        // REF with an open bank, then an unsupported mode.
        do_reset();
        init_seq();
        step(CMD_ACT, 2'd0, 13'h0007);
        step(CMD_REF);
        check("ref_open_err_code", err_code, 16'd4);
        step(CMD_MRS, 2'd0, 13'h021);
        check("mode_unsup_code_kept", err_code, 16'd4);
        step(CMD_WRITE, 2'd0, 13'h001, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        step(CMD_READ, 2'd0, 13'h001);
        step(CMD_NOP); check("cl_kept_T1", dq_seen, IDLE);
        step(CMD_NOP); check("cl_kept_T2", dq_seen, 16'h5A5A);
        step(CMD_NOP); check("cl_kept_T3", dq_seen, IDLE);

        // Back-to-back reads, bus conflict, reset mid-read.
        do_reset();
        init_seq();
        step(CMD_ACT, 2'd0, 13'h0010);
        step(CMD_ACT, 2'd3, 13'h0011);
        step(CMD_WRITE, 2'd0, 13'h004, 1'b0, 1'b0, 1'b1, 16'h1111);
        step(CMD_WRITE, 2'd3, 13'h004, 1'b0, 1'b0, 1'b1, 16'h2222);
        step(CMD_READ, 2'd0, 13'h004);
        step(CMD_READ, 2'd3, 13'h004);
        step(CMD_NOP); check("b2b_T2", dq_seen, 16'h1111);
        step(CMD_NOP); check("b2b_T3", dq_seen, 16'h2222);
        check("b2b_no_err", err, 16'd0);
        step(CMD_READ, 2'd0, 13'h004);
        step(CMD_READ, 2'd3, 13'h004);
        step(CMD_WRITE, 2'd0, 13'h006, 1'b0, 1'b0, 1'b1, 16'h4444);
        check("conflict_no_drive", dq_seen, 16'h4444);
        check("conflict_err_code", err_code, 16'd6);
        step(CMD_NOP); check("conflict_next_slot", dq_seen, 16'h2222);
        step(CMD_READ, 2'd0, 13'h006);
        step(CMD_NOP); step(CMD_NOP);
        check("conflict_write_landed", dq_seen, 16'h4444);
        step(CMD_READ, 2'd0, 13'h004);
        rst = 1'b0;
        step(CMD_NOP);
        rst = 1'b1;
        step(CMD_NOP); check("rst_mid_read_T2", dq_seen, IDLE);
        step(CMD_NOP); check("rst_mid_read_T3", dq_seen, IDLE);
        step(CMD_NOP); check("rst_mid_read_T4", dq_seen, IDLE);
        check("rst_mid_read_err", err, 16'd0);
        check("rst_mid_read_init_done", init_done, 16'd0);

        // Randomized traffic on four open banks against the word model.
        do_reset();
        init_seq();
        cl = $urandom_range(2, 3);
        step(CMD_MRS, 2'd0, 13'(cl << 4));
        for (int unsigned i = 0; i < 4; i++) begin
            rows[i] = $urandom_range(0, 8191);
            step(CMD_ACT, 2'(i), 13'(rows[i]));
        end
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                d = 16'($urandom) & 16'hFFFE;
                step(CMD_WRITE, 2'(i), 13'(j), 1'b0, 1'b0, 1'b1, d);
                model_write(i, j, d, 1'b0, 1'b0);
            end
        end
        for (int n = 0; n < 300; n++) begin
            e    = edge_n + 1;
            slot = due.exists(e);
            op   = $urandom_range(0, 2);
            b    = $urandom_range(0, 3);
            c    = $urandom_range(0, 7);
            exp  = slot ? due[e] : IDLE;
            if (op == 1 && !slot) begin
                d  = 16'($urandom) & 16'hFFFE;
                lm = 1'($urandom_range(0, 1));
                um = 1'($urandom_range(0, 1));
                step(CMD_WRITE, 2'(b), 13'(c), lm, um, 1'b1, d);
                model_write(b, c, d, lm, um);
                exp = d;
            end else if (op == 2) begin
                due[e + cl] = model[widx(b, rows[b], c)];
                step(CMD_READ, 2'(b), 13'(c));
            end else begin
                step(CMD_NOP);
            end
            check("rand_dq", dq_seen, exp);
            if (slot) due.delete(e);
        end
        for (int n = 0; n < 4; n++) begin
            e   = edge_n + 1;
            exp = due.exists(e) ? due[e] : IDLE;
            step(CMD_NOP);
            check("rand_drain_dq", dq_seen, exp);
            if (due.exists(e)) due.delete(e);
        end
        check("rand_no_err", err, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
